// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
//
// Instruction-fetch front end: holds the fetch PC, accepts words returned by
// the memory controller into a small circular queue, and presents the queue
// head to decode. A branch redirect from execute flushes the queue, reloads
// the PC and pulses branch_interception_o so the memory controller can abort
// whatever fetch it has in flight.
//
// Parameters
//   DEPTH     queue entries (power of two, >= 2)
//   RESET_PC  fetch address after reset
//
// Ports
//   clk                    clock, all state updates on rising edge
//   rst                    synchronous active-high reset
//   inst_available_i       one-cycle pulse: returned word valid
//   inst_i                 returned instruction word
//   inst_addr_i            address the returned word was fetched from
//   branch_flag_i          redirect request from execute
//   branch_target_i        redirect address
//   id_stall_i             decode cannot accept this cycle
//   inst_addr_o            fetch request address (current PC)
//   ifid_stall_o           memory controller must not start a new fetch
//   branch_interception_o  one-cycle pulse after each redirect
//   id_valid_o             queue head valid
//   id_inst_o              queue head instruction (0 when empty)
//   id_pc_o                queue head address (0 when empty)
// ---------------------------------------------------------------------------
module if_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_available_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        id_stall_i,
    output logic [31:0] inst_addr_o,
    output logic        ifid_stall_o,
    output logic        branch_interception_o,
    output logic        id_valid_o,
    output logic [31:0] id_inst_o,
    output logic [31:0] id_pc_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so the count can represent a completely full queue.
    localparam int CNT_W = PTR_W + 1;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic             branch_int_q, branch_int_d;

    // Queue storage; contents are never reset, the count alone says what is
    // meaningful.
    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] inst_mem [DEPTH];

    // -----------------------------------------------------------------------
    // Push / pop qualification
    // -----------------------------------------------------------------------
    logic queue_full;
    logic queue_empty;
    logic addr_match;
    logic push_en;
    logic pop_en;

    always_comb begin
        queue_full  = (count_q == CNT_W'(DEPTH));
        queue_empty = (count_q == '0);
        // A word fetched from any address other than the current PC belongs
        // to a fetch stream that has since been abandoned (redirect, or a
        // refetch after a full-queue drop) and is silently discarded.
        addr_match  = (inst_addr_i == pc_q);
        push_en     = inst_available_i && addr_match && !queue_full && !branch_flag_i;
        pop_en      = !queue_empty && !id_stall_i && !branch_flag_i;
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        pc_d         = pc_q;
        count_d      = count_q;
        head_d       = head_q;
        tail_d       = tail_q;
        branch_int_d = 1'b0;

        if (branch_flag_i) begin
            // Redirect flushes everything; a word returning in the same cycle
            // is from the old stream and is dropped along with the queue.
            pc_d         = branch_target_i;
            count_d      = '0;
            head_d       = '0;
            tail_d       = '0;
            branch_int_d = 1'b1;
        end else begin
            if (push_en) begin
                // Plain 32-bit add: the PC wraps from 0xFFFFFFFC to 0.
                pc_d   = pc_q + 32'd4;
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop_en) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            count_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            branch_int_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            count_q      <= count_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            branch_int_q <= branch_int_d;
        end
    end

    // Storage write is gated by push_en, which already excludes redirects;
    // reset need not block it since the count is cleared anyway.
    always_ff @(posedge clk) begin
        if (push_en) begin
            pc_mem[tail_q]   <= inst_addr_i;
            inst_mem[tail_q] <= inst_i;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        inst_addr_o           = pc_q;
        // Throttle one entry early so a fetch already issued still has room.
        ifid_stall_o          = (count_q >= CNT_W'(DEPTH - 1));
        branch_interception_o = branch_int_q;
        id_valid_o            = !queue_empty;
        id_inst_o             = '0;
        id_pc_o               = '0;
        if (!queue_empty) begin
            id_inst_o = inst_mem[head_q];
            id_pc_o   = pc_mem[head_q];
        end
    end

endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction queue entries (power of two, >=2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, fetch address after reset.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 inst_available_i  input  1  one-cycle pulse from memory controller: fetched word valid.
REQ-006 inst_i  input  32  fetched instruction word, valid with inst_available_i.
REQ-007 inst_addr_i  input  32  address the returned word was fetched from.
REQ-008 branch_flag_i  input  1  redirect request from execute.
REQ-009 branch_target_i  input  32  redirect address, valid with branch_flag_i.
REQ-010 id_stall_i  input  1  decode cannot accept this cycle.
REQ-011 inst_addr_o  output  32  fetch request address to memory controller.
REQ-012 ifid_stall_o  output  1  memory controller must not start a new instruction fetch.
REQ-013 branch_interception_o  output  1  one-cycle pulse aborting in-flight fetch.
REQ-014 id_valid_o  output  1  queue head valid for decode.
REQ-015 id_inst_o  output  32  queue head instruction.
REQ-016 id_pc_o  output  32  queue head address.

Function
REQ-017 SHALL hold registered pc; inst_addr_o SHALL equal pc combinationally.
REQ-018 SHALL keep a DEPTH-entry circular FIFO of {pc, inst} with head/tail pointers wrapping modulo DEPTH and count 0..DEPTH.
REQ-019 Push condition: inst_available_i=1, inst_addr_i==pc, count<DEPTH, branch_flag_i=0; on push write {inst_addr_i, inst_i} at tail, tail+1, pc <= pc+4 (32-bit wrap, 32'hFFFFFFFC -> 32'h0).
REQ-020 Returned word with inst_addr_i!=pc (stale) SHALL be discarded, pc unchanged.
REQ-021 Returned word while count==DEPTH SHALL be discarded, pc unchanged (refetched later).
REQ-022 id_valid_o SHALL be (count!=0); id_inst_o/id_pc_o SHALL be head entry combinationally; 0 when empty.
REQ-023 Pop condition: id_valid_o=1, id_stall_i=0, branch_flag_i=0; head advances one entry.
REQ-024 Simultaneous push and pop SHALL leave count unchanged, both pointers advance.
REQ-025 ifid_stall_o SHALL be (count >= DEPTH-1), combinational from registered count.
REQ-026 branch_flag_i=1 SHALL, next cycle: pc=branch_target_i, count=0, head=tail=0, branch_interception_o=1 for exactly that one cycle; same-cycle push and pop suppressed.
REQ-027 Back-to-back branch_flag_i cycles: each applies; last target wins; branch_interception_o stays high while consecutive.
REQ-028 Latency: returned word visible on id_* the cycle after inst_available_i when queue was empty.

Reset
REQ-029 On rst=1 at posedge: pc=RESET_PC, count=0, head=tail=0, branch_interception_o=0; hence id_valid_o=0, id_inst_o=0, id_pc_o=0, ifid_stall_o=0, inst_addr_o=RESET_PC.
REQ-030 rst SHALL override branch_flag_i, inst_available_i and pop in the same cycle; queue contents need not be cleared.

Verification
REQ-031 Reset, then inst_available_i with addr 0x0 inst 0x00000013 -> next cycle id_valid_o=1, id_pc_o=0x0, id_inst_o=0x00000013, inst_addr_o=0x4.
REQ-032 id_stall_i=1, return words at 0x0,0x4,0x8 -> ifid_stall_o=1 after third (count 3); fourth at 0xC -> count 4; fifth at 0x10 discarded, pc stays 0x10.
REQ-033 Queue holds 2, branch_flag_i with target 0x100 -> next cycle id_valid_o=0, inst_addr_o=0x100, branch_interception_o=1 one cycle; later word with addr 0x8 discarded.
REQ-034 Push and pop same cycle at count 2 -> count stays 2, id_pc_o advances by 4; pointer wrap after 6 such cycles with DEPTH=4 yields in-order pcs.
REQ-035 Branch and inst_available_i same cycle -> word dropped, pc=target; rst mid-fill -> id_valid_o=0, inst_addr_o=RESET_PC next cycle.
